// File: rtl/btn_pkg.sv
// Shared constants for the push-button debounce bank: default debounce interval
// and the per-channel LED mode encoding.
package btn_pkg;

    localparam int   DEBOUNCE_10MS_12MHZ = 120000;

    localparam logic MODE_MOMENTARY = 1'b0;
    localparam logic MODE_TOGGLE    = 1'b1;

endpackage

// File: rtl/button_debounce_ch.sv
// One debounced button channel: two-flop synchroniser, consecutive-cycle stability
// counter, press/release strobes and a press-driven toggle register.
module button_debounce_ch
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_10MS_12MHZ,
    parameter bit ACTIVE_LOW      = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    input  logic mode,
    output logic pressed,
    output logic press_pulse,
    output logic release_pulse,
    output logic led
);

    localparam int               CNT_W        = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic             RELEASED_RAW = ACTIVE_LOW;

    logic             sync1;
    logic             sync2;
    logic             s;
    logic             stable;
    logic             toggle;
    logic             accept;
    logic [CNT_W-1:0] cnt;

    // NOTE: the synchroniser resets to the idle pin level, not to 0, so leaving
    // reset with an active-low button released is not mistaken for a press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= RELEASED_RAW;
            sync2 <= RELEASED_RAW;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
        end
    end

    assign s      = sync2 ^ ACTIVE_LOW;
    assign accept = (s != stable) && (cnt == CNT_LAST);

    // NOTE: non-blocking assignments here, so accept, cnt and stable are all
    // evaluated from their pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt           <= '0;
            stable        <= 1'b0;
            toggle        <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            press_pulse   <= accept && s;
            release_pulse <= accept && !s;
            // Any return to the accepted level forfeits the whole count.
            if ((s == stable) || accept) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
            if (accept) begin
                stable <= s;
            end
            if (accept && s) begin
                toggle <= ~toggle;
            end
        end
    end

    assign pressed = stable;
    assign led     = (mode == MODE_TOGGLE) ? toggle : stable;

endmodule

// File: rtl/button_debounce_bank.sv
// Bank of N_CH independent debounced button channels with per-channel
// momentary/toggle LED drive.
module button_debounce_bank
    import btn_pkg::*;
#(
    parameter int N_CH            = 4,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_10MS_12MHZ,
    parameter bit ACTIVE_LOW      = 1'b0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] btn,
    input  logic [N_CH-1:0] mode,
    output logic [N_CH-1:0] pressed,
    output logic [N_CH-1:0] press_pulse,
    output logic [N_CH-1:0] release_pulse,
    output logic [N_CH-1:0] led
);

    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("button_debounce_bank: DEBOUNCE_CYCLES must be >= 1");
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        button_debounce_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .ACTIVE_LOW      (ACTIVE_LOW)
        ) u_ch (
            .clk           (clk),
            .rst_n         (rst_n),
            .btn           (btn[i]),
            .mode          (mode[i]),
            .pressed       (pressed[i]),
            .press_pulse   (press_pulse[i]),
            .release_pulse (release_pulse[i]),
            .led           (led[i])
        );
    end

endmodule

// File: tb/tb_button_debounce_bank.sv
// Self-checking bench for button_debounce_bank: an active-high and an active-low
// bank share clock and reset; a window-based reference model feeds a scoreboard.
module tb_button_debounce_bank;

    localparam int N_CH = 4;
    localparam int DB   = 8;
    localparam int HL   = DB + 2;

    typedef struct packed {
        logic [N_CH-1:0] pressed;
        logic [N_CH-1:0] pp;
        logic [N_CH-1:0] rp;
        logic [N_CH-1:0] tog;
    } snap_t;

    logic            clk   = 1'b0;
    logic            rst_n = 1'b0;
    logic [N_CH-1:0] btn0  = '0;
    logic [N_CH-1:0] mode0 = '0;
    logic [N_CH-1:0] btn1  = '1;
    logic [N_CH-1:0] mode1 = '0;
    logic [N_CH-1:0] pressed0, pp0, rp0, led0;
    logic [N_CH-1:0] pressed1, pp1, rp1, led1;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    button_debounce_bank #(
        .N_CH(N_CH), .DEBOUNCE_CYCLES(DB), .ACTIVE_LOW(1'b0)
    ) dut0 (
        .clk(clk), .rst_n(rst_n), .btn(btn0), .mode(mode0),
        .pressed(pressed0), .press_pulse(pp0), .release_pulse(rp0), .led(led0)
    );

    button_debounce_bank #(
        .N_CH(N_CH), .DEBOUNCE_CYCLES(DB), .ACTIVE_LOW(1'b1)
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .btn(btn1), .mode(mode1),
        .pressed(pressed1), .press_pulse(pp1), .release_pulse(rp1), .led(led1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // A change is accepted on the edge where the normalised pin, as seen two edges
    // late through the synchroniser, has differed from the accepted level on each
    // of the last DB edges. hist[u][m] is the normalised pin sampled m edges ago.
    logic [N_CH-1:0] hist [2][HL];
    logic [N_CH-1:0] m_stable [2];
    logic [N_CH-1:0] m_tog [2];
    snap_t q0[$];
    snap_t q1[$];
    snap_t sn;
    bit    held;

    task automatic model_reset();
        for (int u = 0; u < 2; u++) begin
            m_stable[u] = '0;
            m_tog[u]    = '0;
            for (int m = 0; m < HL; m++) hist[u][m] = '0;
        end
        q0.delete();
        q1.delete();
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_reset();
        end else begin
            for (int u = 0; u < 2; u++) begin
                for (int m = HL - 1; m > 0; m--) hist[u][m] = hist[u][m-1];
                hist[u][0] = (u == 0) ? btn0 : ~btn1;
                sn.pp = '0;
                sn.rp = '0;
                for (int c = 0; c < N_CH; c++) begin
                    held = 1'b1;
                    for (int m = 2; m < HL; m++)
                        if (hist[u][m][c] == m_stable[u][c]) held = 1'b0;
                    if (held) begin
                        m_stable[u][c] = hist[u][2][c];
                        if (m_stable[u][c]) begin
                            sn.pp[c]    = 1'b1;
                            m_tog[u][c] = ~m_tog[u][c];
                        end else begin
                            sn.rp[c] = 1'b1;
                        end
                    end
                end
                sn.pressed = m_stable[u];
                sn.tog     = m_tog[u];
                if (u == 0) q0.push_back(sn);
                else        q1.push_back(sn);
            end
        end
    end

    // ---------------- scoreboard monitor ----------------
    snap_t exp0, exp1;

    always @(negedge clk) begin
        if (!rst_n) begin
            check("sb_rst_out0", {pressed0, pp0, rp0, led0}, '0);
            check("sb_rst_out1", {pressed1, pp1, rp1, led1}, '0);
        end else begin
            exp0 = '0;
            exp1 = '0;
            if (q0.size() != 0) exp0 = q0.pop_front();
            if (q1.size() != 0) exp1 = q1.pop_front();
            check("sb_pressed0", pressed0, exp0.pressed);
            check("sb_press0",   pp0,      exp0.pp);
            check("sb_release0", rp0,      exp0.rp);
            check("sb_led0",     led0,     (mode0 & exp0.tog) | (~mode0 & exp0.pressed));
            check("sb_pressed1", pressed1, exp1.pressed);
            check("sb_press1",   pp1,      exp1.pp);
            check("sb_release1", rp1,      exp1.rp);
            check("sb_led1",     led1,     (mode1 & exp1.tog) | (~mode1 & exp1.pressed));
        end
    end

    // ---------------- stimulus with directed spot checks ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    logic [N_CH-1:0] act;
    int              npulse;
    int              at;

    initial begin
        // Reset with buttons released, then release reset.
        tick(3);
        check("rst_hold_out0", {pressed0, pp0, rp0, led0}, '0);
        check("rst_hold_out1", {pressed1, pp1, rp1, led1}, '0);
        rst_n = 1'b1;
        tick(1);
        check("rst_first_edge0", {pressed0, pp0, rp0, led0}, '0);
        check("rst_first_edge1", {pressed1, pp1, rp1, led1}, '0);

        // Clean press and release on channel 0.
        btn0[0] = 1'b1;
        tick(9);
        check("clean_press_early", {pressed0, pp0}, '0);
        tick(1);
        check("clean_press_level", pressed0, 4'b0001);
        check("clean_press_pulse", pp0, 4'b0001);
        tick(1);
        check("clean_press_pulse_end", pp0, 4'b0000);
        btn0[0] = 1'b0;
        tick(9);
        check("clean_rel_early", rp0, 4'b0000);
        tick(1);
        check("clean_rel_pulse", rp0, 4'b0001);
        check("clean_rel_level", pressed0, 4'b0000);
        tick(1);
        check("clean_rel_pulse_end", rp0, 4'b0000);

        // Bouncing input on channel 1: 3 high / 2 low for 40 cycles, then held.
        act = '0;
        for (int i = 0; i < 8; i++) begin
            btn0[1] = 1'b1;
            repeat (3) begin tick(1); act |= pp0 | rp0 | pressed0; end
            btn0[1] = 1'b0;
            repeat (2) begin tick(1); act |= pp0 | rp0 | pressed0; end
        end
        check("bounce_quiet", act, '0);
        btn0[1] = 1'b1;
        npulse = 0;
        at     = 0;
        for (int i = 1; i <= 12; i++) begin
            tick(1);
            if (pp0[1]) begin npulse++; at = i; end
        end
        check("bounce_pulse_count", npulse, 1);
        check("bounce_pulse_edge", at, 10);
        btn0[1] = 1'b0;
        tick(12);

        // Toggle mode on channel 2.
        mode0 = 4'b0100;
        for (int p = 0; p < 3; p++) begin
            btn0[2] = 1'b1;
            tick(12);
            check("toggle_after_press", led0[2], (p % 2 == 0) ? 1 : 0);
            btn0[2] = 1'b0;
            tick(12);
            check("toggle_after_release", led0[2], (p % 2 == 0) ? 1 : 0);
        end
        mode0[2] = 1'b0;
        #1;
        check("mode_flip_same_cycle", led0[2], 0);

        // Active-low bank: simultaneous press, then staggered press.
        btn1 = '0;
        tick(9);
        check("al_press_early", pp1, 4'b0000);
        tick(1);
        check("al_press_all", pp1, 4'b1111);
        check("al_level_all", pressed1, 4'b1111);
        tick(1);
        check("al_press_end", pp1, 4'b0000);
        btn1 = '1;
        tick(12);
        check("al_released", pressed1, 4'b0000);
        btn1 = 4'b1000;
        tick(5);
        btn1 = 4'b0000;
        tick(5);
        check("al_stagger_first", pp1, 4'b0111);
        tick(5);
        check("al_stagger_late", pp1, 4'b1000);
        btn1 = '1;
        tick(12);

        // Reset in the middle of a count.
        mode0[2] = 1'b1;
        #1;
        check("pre_reset_led", led0, 4'b0100);
        btn0[0] = 1'b1;
        tick(6);
        rst_n = 1'b0;
        #1;
        check("async_rst_out0", {pressed0, pp0, rp0, led0}, '0);
        check("async_rst_out1", {pressed1, pp1, rp1, led1}, '0);
        tick(2);
        rst_n = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            tick(1);
            check("midcount_no_pulse", pp0, 4'b0000);
        end
        tick(1);
        check("midcount_pulse", pp0, 4'b0001);
        btn0[0] = 1'b0;
        tick(12);

        // Randomised traffic on both banks, checked by the scoreboard.
        for (int i = 0; i < 70; i++) begin
            btn0 = btn0 ^ 4'($urandom_range(0, 15));
            btn1 = btn1 ^ 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) mode0 = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) mode1 = 4'($urandom_range(0, 15));
            tick(int'($urandom_range(1, 14)));
        end
        tick(12);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
